mcyc_controller: RTL and testbench



---
 rtl/mcyc_controller.sv | 98 +++++++++
 tb/tb_mcyc_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mcyc_controller.sv
// mcyc_controller: multicycle control FSM for the 8-bit MIPS-subset datapath.
// One state per clock: four byte fetches, decode, then per-opcode execute/memory/writeback.
module mcyc_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
    SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
  } state_t;
  state_t state_q, state_d;
  logic pcwrite, branch;
  logic [1:0] aluop;
  logic [2:0] funct_alu;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= FETCH1;
    else        state_q <= state_d;
  assign state = state_q;
  always_comb begin
    state_d  = FETCH1;
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    irwrite  = 4'b0000;
    regdst   = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    case (state_q)
      FETCH1:  begin memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0001; state_d = FETCH2; end
      FETCH2:  begin memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0010; state_d = FETCH3; end
      FETCH3:  begin memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0100; state_d = FETCH4; end
      FETCH4:  begin memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b1000; state_d = DECODE; end
      DECODE: begin
        alusrcb = 2'b11;
        state_d = (op == OP_LB || op == OP_SB) ? MEMADR :
                  (op == OP_RTYPE) ? RTYPEEX :
                  (op == OP_BEQ)   ? BEQEX   :
                  (op == OP_J)     ? JEX     :
                  (op == OP_ADDI)  ? ADDIEX  : FETCH1;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LB) ? LBRD : (op == OP_SB) ? SBWR : FETCH1;
      end
      LBRD:    begin memread = 1'b1; iord = 1'b1; state_d = LBWR; end
      LBWR:    begin regwrite = 1'b1; memtoreg = 1'b1; end
      SBWR:    begin memwrite = 1'b1; iord = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; state_d = RTYPEWR; end
      RTYPEWR: begin regwrite = 1'b1; regdst = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; state_d = ADDIWR; end
      ADDIWR:  regwrite = 1'b1;
      default: state_d = FETCH1;
    endcase
    funct_alu = (funct == 6'b100010) ? 3'b110 :
                (funct == 6'b100100) ? 3'b000 :
                (funct == 6'b100101) ? 3'b001 :
                (funct == 6'b101010) ? 3'b111 : 3'b010;
    alucontrol = (aluop == 2'b01) ? 3'b110 : (aluop == 2'b10) ? funct_alu : 3'b010;
    pcen = pcwrite | (branch & zero);
    // Reset holds every control output low, combinationally, ahead of the flop.
    if (!reset) begin
      {memread, memwrite, alusrca, alusrcb, pcsrc, pcen, iord} = '0;
      {irwrite, regdst, regwrite, memtoreg, alucontrol} = '0;
    end
  end
endmodule

// File: tb/tb_mcyc_controller.sv
// tb_mcyc_controller: random instruction streams checked every cycle against an
// instruction-level model, plus directed pins for fetch, each opcode, and reset.
module tb_mcyc_controller;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LB = 6'b100000, OP_SB = 6'b101000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic memread, memwrite, alusrca, pcen, iord, regdst, regwrite, memtoreg;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] irwrite, state;
  logic [2:0] alucontrol;
  typedef struct packed {
    logic memread; logic memwrite; logic alusrca; logic [1:0] alusrcb; logic [1:0] pcsrc;
    logic pcen; logic iord; logic [3:0] irwrite; logic regdst; logic regwrite;
    logic memtoreg; logic [2:0] alucontrol; logic [3:0] state;
  } ov_t;
  ov_t act, exp_v;
  ov_t hist [16];
  logic chk_en = 1'b0;
  int total = 0, bad = 0;

  mcyc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .iord(iord), .irwrite(irwrite), .regdst(regdst),
    .regwrite(regwrite), .memtoreg(memtoreg), .alucontrol(alucontrol), .state(state)
  );

  assign act = {memread, memwrite, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
                regdst, regwrite, memtoreg, alucontrol, state};

  always #5 clk = ~clk;

  always @(negedge clk)
    if (chk_en) begin
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL cycle t=%0t outputs act=%h exp=%h", $time, act, exp_v);
      end
    end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h", name, a, e);
    end
  endtask

  function automatic int steps(input logic [5:0] o);
    return (o == OP_LB) ? 3 : (o == OP_SB || o == OP_RTYPE || o == OP_ADDI) ? 2 :
           (o == OP_BEQ || o == OP_J) ? 1 : 0;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for step k of an instruction with opcode o.
  function automatic ov_t model(input int k, input logic [5:0] o, input logic [5:0] f, input logic z);
    ov_t v = '0;
    int j = k - 5;
    v.alucontrol = 3'b010;
    if (k < 4) begin
      v.memread = 1'b1; v.alusrcb = 2'b01; v.pcen = 1'b1;
      v.irwrite = 4'(1 << k); v.state = 4'(k);
    end else if (k == 4) begin
      v.alusrcb = 2'b11; v.state = 4'd4;
    end else if (o == OP_LB || o == OP_SB) begin
      if (j == 0) begin v.alusrca = 1'b1; v.alusrcb = 2'b10; v.state = 4'd5; end
      else if (o == OP_SB) begin v.memwrite = 1'b1; v.iord = 1'b1; v.state = 4'd8; end
      else if (j == 1) begin v.memread = 1'b1; v.iord = 1'b1; v.state = 4'd6; end
      else begin v.regwrite = 1'b1; v.memtoreg = 1'b1; v.state = 4'd7; end
    end else if (o == OP_RTYPE) begin
      if (j == 0) begin v.alusrca = 1'b1; v.alucontrol = alu_of(f); v.state = 4'd9; end
      else begin v.regwrite = 1'b1; v.regdst = 1'b1; v.state = 4'd10; end
    end else if (o == OP_BEQ) begin
      v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = z; v.state = 4'd11;
    end else if (o == OP_J) begin
      v.pcsrc = 2'b10; v.pcen = 1'b1; v.state = 4'd12;
    end else begin
      if (j == 0) begin v.alusrca = 1'b1; v.alusrcb = 2'b10; v.state = 4'd13; end
      else begin v.regwrite = 1'b1; v.state = 4'd14; end
    end
    return v;
  endfunction

  // Entered just after a rising edge with the DUT in FETCH1; leaves just after a rising edge.
  task automatic run(input logic [5:0] o, input logic [5:0] f, input int zm, input int stop = 99);
    int n = 5 + steps(o);
    for (int k = 0; k < n && k < stop; k++) begin
      op    = (k < 4) ? 6'($urandom) : o;
      funct = (k < 4) ? 6'($urandom) : f;
      zero  = (zm == 2) ? 1'($urandom) : zm[0];
      exp_v = model(k, o, f, zero);
      chk_en = 1'b1;
      @(negedge clk);
      hist[k] = act;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic legal(input logic [5:0] o);
    return o == OP_RTYPE || o == OP_LB || o == OP_SB || o == OP_BEQ || o == OP_J || o == OP_ADDI;
  endfunction

  initial begin
    logic [5:0] fs [5];
    logic [2:0] es [5];
    logic [5:0] fl [5];
    logic [5:0] o;
    fs = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    es = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    op = OP_LB; zero = 1'b1;
    #3 chk("reset_outs", 32'(act), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 32'(act), 32'h0);
    reset = 1'b1;
    run(OP_RTYPE, 6'b100000, 2);
    chk("add_f1_irw", 32'(hist[0].irwrite), 32'b0001);
    chk("add_f1_pcen", 32'(hist[0].pcen), 32'd1);
    chk("add_f2_irw", 32'(hist[1].irwrite), 32'b0010);
    chk("add_f3_irw", 32'(hist[2].irwrite), 32'b0100);
    chk("add_f4_irw", 32'(hist[3].irwrite), 32'b1000);
    chk("add_ex_state", 32'(hist[5].state), 32'd9);
    chk("add_ex_alu", 32'({hist[5].alucontrol, hist[5].alusrca, hist[5].alusrcb}), 32'b010_1_00);
    chk("add_wr", 32'({hist[6].regwrite, hist[6].regdst}), 32'b11);
    chk("add_done", 32'(state), 32'd0);
    run(OP_LB, 6'h00, 2);
    chk("lb_memadr_b", 32'(hist[5].alusrcb), 32'b10);
    chk("lb_rd", 32'({hist[6].memread, hist[6].iord}), 32'b11);
    chk("lb_wr", 32'({hist[7].regwrite, hist[7].memtoreg}), 32'b11);
    chk("lb_done", 32'(state), 32'd0);
    run(OP_BEQ, 6'h00, 1);
    chk("beq_z1", 32'({hist[5].pcen, hist[5].pcsrc, hist[5].alucontrol}), 32'b1_01_110);
    run(OP_BEQ, 6'h00, 0);
    chk("beq_z0_pcen", 32'(hist[5].pcen), 32'd0);
    chk("beq_done", 32'(state), 32'd0);
    run(OP_J, 6'h00, 2);
    chk("j_ex", 32'({hist[5].pcsrc, hist[5].pcen}), 32'b10_1);
    run(6'b111111, 6'h00, 2);
    chk("bad_op_decode", 32'(hist[4].state), 32'd4);
    chk("bad_op_done", 32'(state), 32'd0);
    for (int i = 0; i < 5; i++) begin
      run(OP_RTYPE, fs[i], 2);
      chk($sformatf("funct_%b", fs[i]), 32'(hist[5].alucontrol), 32'(es[i]));
    end
    run(OP_LB, 6'h00, 2, 6);
    chk_en = 1'b0;
    chk("lbrd_reached", 32'({state, memread, iord}), 32'b0110_1_1);
    #2 reset = 1'b0;
    #1 chk("rst_async", 32'(act), 32'h0);
    @(posedge clk);
    #1 chk("rst_edge", 32'(act), 32'h0);
    reset = 1'b1;
    run(OP_SB, 6'h00, 2);
    chk("rst_resume_irw", 32'(hist[0].irwrite), 32'b0001);
    repeat (300) begin
      case ($urandom_range(0, 6))
        0: o = OP_RTYPE;
        1: o = OP_LB;
        2: o = OP_SB;
        3: o = OP_BEQ;
        4: o = OP_J;
        5: o = OP_ADDI;
        default: begin
          o = 6'($urandom);
          while (legal(o)) o = 6'($urandom);
        end
      endcase
      run(o, $urandom_range(0, 1) ? fl[$urandom_range(0, 4)] : 6'($urandom), 2);
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
